// File: rtl/object_commander.sv
`default_nettype none
// ============================================================================
//  Module      : object_commander
//  Description : Bus master for the addressed-object command bus. Queues
//                (address, command) requests, drives each one onto the shared
//                bus for a single cycle, reads the target's status bit back
//                and re-drives on mismatch until the retry budget runs out.
//  Revision    : 1.0 - initial release
// ============================================================================
module object_commander #(
  parameter int ADDR_W     = 5,
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_RETRY  = 3
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic [ADDR_W-1:0]        req_addr_i,
  input  logic                     req_cmd_i,
  output logic [ADDR_W-1:0]        address_o,
  output logic                     command_o,
  input  logic [(2**ADDR_W)-1:0]   status_i,
  output logic                     done_o,
  output logic [ADDR_W-1:0]        done_addr_o,
  output logic                     err_o,
  output logic                     busy_o
);

  // Pointer index width; one extra wrap bit separates full from empty.
  localparam int c_ptr_w   = $clog2(FIFO_DEPTH);
  // Retry counter only needs to reach MAX_RETRY; it saturates there.
  localparam int c_retry_w = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [c_retry_w-1:0] c_max_retry = c_retry_w'(MAX_RETRY);
  localparam logic [c_retry_w-1:0] c_retry_one = c_retry_w'(1);
  localparam logic [c_ptr_w:0]     c_ptr_one   = (c_ptr_w + 1)'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_CHECK = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // Request queue
  // --------------------------------------------------------------------------
  logic [ADDR_W-1:0] r_fifo_addr [FIFO_DEPTH];
  logic              r_fifo_cmd  [FIFO_DEPTH];
  logic [c_ptr_w:0]  r_wr_ptr;
  logic [c_ptr_w:0]  r_rd_ptr;

  logic              w_empty;
  logic              w_full;
  logic              w_push;
  logic              w_pop;
  logic [ADDR_W-1:0] w_head_addr;
  logic              w_head_cmd;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[c_ptr_w] != r_rd_ptr[c_ptr_w]) &&
                   (r_wr_ptr[c_ptr_w-1:0] == r_rd_ptr[c_ptr_w-1:0]);

  // Ready depends on fullness alone, so a same-cycle pop never frees a slot
  // early. Address 0 is the idle code: such requests are accepted and dropped.
  assign req_ready_o = !w_full;
  assign w_push      = req_valid_i && !w_full && (req_addr_i != '0);

  assign w_head_addr = r_fifo_addr[r_rd_ptr[c_ptr_w-1:0]];
  assign w_head_cmd  = r_fifo_cmd[r_rd_ptr[c_ptr_w-1:0]];

  // Queue storage: written on push, no reset needed since pointers guard it.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_fifo_addr[r_wr_ptr[c_ptr_w-1:0]] <= req_addr_i;
      r_fifo_cmd[r_wr_ptr[c_ptr_w-1:0]]  <= req_cmd_i;
    end
  end

  // Queue pointers: reset flushes every queued request.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_one;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_one;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Command sequencer
  // --------------------------------------------------------------------------
  state_t               r_state;
  state_t               w_state_nxt;
  logic [ADDR_W-1:0]    r_addr;
  logic [ADDR_W-1:0]    w_addr_nxt;
  logic                 r_cmd;
  logic                 w_cmd_nxt;
  logic [c_retry_w-1:0] r_retry;
  logic [c_retry_w-1:0] w_retry_nxt;
  logic [ADDR_W-1:0]    r_bus_addr;
  logic [ADDR_W-1:0]    w_bus_addr_nxt;
  logic                 r_bus_cmd;
  logic                 w_bus_cmd_nxt;
  logic                 r_done;
  logic                 w_done_nxt;
  logic [ADDR_W-1:0]    r_done_addr;
  logic [ADDR_W-1:0]    w_done_addr_nxt;
  logic                 r_err;
  logic                 w_err_nxt;
  logic                 w_match;

  // The object has already absorbed the drive by the CHECK cycle.
  assign w_match = (status_i[r_addr] == r_cmd);

  // Next-state and registered-output decode; the bus idles at 0 by default.
  always_comb begin
    w_state_nxt     = r_state;
    w_addr_nxt      = r_addr;
    w_cmd_nxt       = r_cmd;
    w_retry_nxt     = r_retry;
    w_bus_addr_nxt  = '0;
    w_bus_cmd_nxt   = 1'b0;
    w_done_nxt      = 1'b0;
    w_done_addr_nxt = r_done_addr;
    w_err_nxt       = r_err;
    w_pop           = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop          = 1'b1;
          w_addr_nxt     = w_head_addr;
          w_cmd_nxt      = w_head_cmd;
          w_retry_nxt    = '0;
          w_bus_addr_nxt = w_head_addr;
          w_bus_cmd_nxt  = w_head_cmd;
          w_state_nxt    = S_DRIVE;
        end
      end
      S_DRIVE: begin
        // Bus was live for exactly this cycle; release it for the readback.
        w_state_nxt = S_CHECK;
      end
      S_CHECK: begin
        if (w_match) begin
          w_done_nxt      = 1'b1;
          w_err_nxt       = 1'b0;
          w_done_addr_nxt = r_addr;
          w_state_nxt     = S_IDLE;
        end else if (r_retry < c_max_retry) begin
          w_retry_nxt    = r_retry + c_retry_one;
          w_bus_addr_nxt = r_addr;
          w_bus_cmd_nxt  = r_cmd;
          w_state_nxt    = S_DRIVE;
        end else begin
          w_done_nxt      = 1'b1;
          w_err_nxt       = 1'b1;
          w_done_addr_nxt = r_addr;
          w_state_nxt     = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Sequencer state and output registers; reset drops any in-flight request.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_cmd       <= 1'b0;
      r_retry     <= '0;
      r_bus_addr  <= '0;
      r_bus_cmd   <= 1'b0;
      r_done      <= 1'b0;
      r_done_addr <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_addr      <= w_addr_nxt;
      r_cmd       <= w_cmd_nxt;
      r_retry     <= w_retry_nxt;
      r_bus_addr  <= w_bus_addr_nxt;
      r_bus_cmd   <= w_bus_cmd_nxt;
      r_done      <= w_done_nxt;
      r_done_addr <= w_done_addr_nxt;
      r_err       <= w_err_nxt;
    end
  end

  assign address_o   = r_bus_addr;
  assign command_o   = r_bus_cmd;
  assign done_o      = r_done;
  assign done_addr_o = r_done_addr;
  assign err_o       = r_err;
  assign busy_o      = (r_state != S_IDLE) || !w_empty;

endmodule
`default_nettype wire

// File: tb/tb_object_commander.sv
`default_nettype none
// ============================================================================
//  Module      : tb_object_commander
//  Description : Self-checking bench for object_commander with an object
//                array model and a request-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_object_commander;

  localparam int ADDR_W     = 5;
  localparam int FIFO_DEPTH = 4;
  localparam int MAX_RETRY  = 3;
  localparam int N_OBJ      = 1 << ADDR_W;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b1;
  logic              req_valid_i = 1'b0;
  logic              req_ready_o;
  logic [ADDR_W-1:0] req_addr_i = '0;
  logic              req_cmd_i = 1'b0;
  logic [ADDR_W-1:0] address_o;
  logic              command_o;
  logic [N_OBJ-1:0]  status_i;
  logic              done_o;
  logic [ADDR_W-1:0] done_addr_o;
  logic              err_o;
  logic              busy_o;

  object_commander #(
    .ADDR_W     (ADDR_W),
    .FIFO_DEPTH (FIFO_DEPTH),
    .MAX_RETRY  (MAX_RETRY)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_addr_i  (req_addr_i),
    .req_cmd_i   (req_cmd_i),
    .address_o   (address_o),
    .command_o   (command_o),
    .status_i    (status_i),
    .done_o      (done_o),
    .done_addr_o (done_addr_o),
    .err_o       (err_o),
    .busy_o      (busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Object array: each object latches the bus command when addressed;
  // stuck objects report a fixed value regardless.
  logic [N_OBJ-1:0] obj_q     = '0;
  logic [N_OBJ-1:0] stuck_en  = '0;
  logic [N_OBJ-1:0] stuck_val = '0;

  always @(posedge clk_i) begin
    if (rst_i && address_o != '0) obj_q[address_o] <= command_o;
  end

  always_comb status_i = (stuck_en & stuck_val) | (~stuck_en & obj_q);

  // Reference model: requests in acceptance order with their expected outcome.
  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic              cmd;
    logic              err;
    int                push_cyc;
    bit                lat;
  } req_t;

  req_t              q[$];
  req_t              cur;
  bit                inflight = 0;
  int                drives = 0;
  int                cyc = 0;
  int                n_done = 0;
  bit                prev_bus = 0;
  logic [ADDR_W-1:0] last_addr = '0;
  logic              last_err = 1'b0;
  int                n_checks = 0;
  int                n_fail = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Compare the post-edge DUT outputs against the model and advance it.
  task automatic observe();
    bit bus;
    bus = (address_o != '0);
    check_eq("bus_gap", int'(prev_bus && bus), 0);
    if (bus) begin
      if (!inflight) begin
        if (q.size() == 0) begin
          check_eq("spurious_drive", int'(address_o), 0);
        end else begin
          cur      = q.pop_front();
          inflight = 1;
          drives   = 0;
          if (cur.lat) check_eq("drive_latency", cyc - cur.push_cyc, 1);
        end
      end
      drives++;
      if (inflight) begin
        check_eq("drive_addr", int'(address_o), int'(cur.addr));
        check_eq("drive_cmd", int'(command_o), int'(cur.cmd));
      end
    end else begin
      check_eq("idle_cmd", int'(command_o), 0);
    end
    if (done_o) begin
      if (!inflight) begin
        check_eq("spurious_done", int'(done_o), 0);
      end else begin
        check_eq("done_addr", int'(done_addr_o), int'(cur.addr));
        check_eq("done_err", int'(err_o), int'(cur.err));
        check_eq("drive_count", drives, cur.err ? MAX_RETRY + 1 : 1);
        if (cur.lat && !cur.err) check_eq("done_latency", cyc - cur.push_cyc, 3);
        last_addr = cur.addr;
        last_err  = cur.err;
        inflight  = 0;
        n_done++;
      end
    end else begin
      check_eq("done_addr_hold", int'(done_addr_o), int'(last_addr));
      check_eq("err_hold", int'(err_o), int'(last_err));
    end
    check_eq("ready", int'(req_ready_o), int'(q.size() < FIFO_DEPTH));
    check_eq("busy", int'(busy_o), int'(q.size() != 0 || inflight));
    prev_bus = bus;
  endtask

  // One clock: drive inputs at the falling edge, observe 1 unit after rising.
  task automatic cycle(input logic v, input logic [ADDR_W-1:0] a, input logic c);
    bit   acc;
    req_t r;
    @(negedge clk_i);
    req_valid_i = v;
    req_addr_i  = a;
    req_cmd_i   = c;
    #1;
    acc = v && req_ready_o;
    @(posedge clk_i);
    #1;
    cyc++;
    if (acc && a != '0) begin
      r.addr     = a;
      r.cmd      = c;
      r.err      = stuck_en[a] && (stuck_val[a] != c);
      r.push_cyc = cyc;
      r.lat      = (q.size() == 0) && !inflight;
      q.push_back(r);
    end
    observe();
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && (q.size() != 0 || inflight); i++) cycle(1'b0, '0, 1'b0);
    check_eq("drain_timeout", int'(q.size() != 0 || inflight), 0);
    repeat (3) cycle(1'b0, '0, 1'b0);
  endtask

  // Asynchronous reset applied mid-cycle, released on a falling edge.
  task automatic do_reset();
    #2;
    req_valid_i = 1'b0;
    rst_i       = 1'b0;
    #1;
    check_eq("rst_addr", int'(address_o), 0);
    check_eq("rst_cmd", int'(command_o), 0);
    check_eq("rst_done", int'(done_o), 0);
    check_eq("rst_busy", int'(busy_o), 0);
    q.delete();
    inflight  = 0;
    prev_bus  = 0;
    last_addr = '0;
    last_err  = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    check_eq("rel_ready", int'(req_ready_o), 1);
    check_eq("rel_busy", int'(busy_o), 0);
    check_eq("rel_done_addr", int'(done_addr_o), 0);
    check_eq("rel_err", int'(err_o), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    do_reset();
    cycle(1'b0, '0, 1'b0);

    // Single cooperative request with latency checks.
    cycle(1'b1, 5'd5, 1'b1);
    drain();
    check_eq("obj5", int'(status_i[5]), 1);

    // Stuck object exhausts retries while four more requests fill the queue.
    stuck_en[7]  = 1'b1;
    stuck_val[7] = 1'b0;
    d0 = n_done;
    cycle(1'b1, 5'd7, 1'b1);
    for (int i = 1; i <= 4; i++) cycle(1'b1, ADDR_W'(i), 1'($urandom_range(0, 1)));
    check_eq("full_ready", int'(req_ready_o), 0);
    cycle(1'b1, 5'd5, 1'b1);
    drain();
    check_eq("blocked_dones", n_done - d0, 5);

    // Idle-code request: accepted, no activity.
    d0 = n_done;
    cycle(1'b1, 5'd0, 1'b1);
    repeat (6) cycle(1'b0, '0, 1'b0);
    check_eq("zero_dones", n_done - d0, 0);

    // Reset while driving with three requests queued.
    for (int i = 10; i <= 14; i++) cycle(1'b1, ADDR_W'(i), 1'b1);
    check_eq("pre_rst_drive", int'(address_o), 11);
    do_reset();
    d0 = n_done;
    repeat (10) cycle(1'b0, '0, 1'b0);
    check_eq("post_rst_dones", n_done - d0, 0);

    // Back-to-back set then clear of one object.
    d0 = n_done;
    cycle(1'b1, 5'd9, 1'b1);
    cycle(1'b1, 5'd9, 1'b0);
    drain();
    check_eq("alt_dones", n_done - d0, 2);
    check_eq("obj9", int'(status_i[9]), 0);

    // Randomized traffic with a few stuck objects.
    for (int k = 0; k < 3; k++) begin
      int a;
      a = $urandom_range(16, 31);
      stuck_en[a]  = 1'b1;
      stuck_val[a] = 1'($urandom_range(0, 1));
    end
    for (int i = 0; i < 500; i++)
      cycle(1'($urandom_range(0, 99) < 45), ADDR_W'($urandom_range(0, N_OBJ - 1)),
            1'($urandom_range(0, 1)));
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
